// File: rtl/pwm_multi.sv
// pwm_multi: CH-channel PWM sharing one period counter, edge/center aligned, double-buffered duty/period/mode
module pwm_multi #(
    parameter int CH    = 4,
    parameter int WIDTH = 10,
    parameter int SELW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [SELW-1:0]  ch_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             center_in,
    input  logic [CH-1:0]    invert,
    output logic [CH-1:0]    pwm_out,
    output logic             period_start
);
    logic [WIDTH-1:0] cnt_q, cnt_d, top_sh_q, top_act_q;
    logic             dir_q, dir_d, mode_sh_q, mode_act_q, ps_q;
    logic [WIDTH-1:0] duty_sh_q  [CH];
    logic [WIDTH-1:0] duty_act_q [CH];
    logic [CH-1:0]    pwm_q, cmp;
    logic             at_top, boundary;

    always_comb begin
        at_top = cnt_q >= top_act_q;
        if (!enable) cnt_d = '0;
        else if (!mode_act_q) cnt_d = at_top ? '0 : cnt_q + WIDTH'(1);
        else if (!dir_q && !at_top) cnt_d = cnt_q + WIDTH'(1);
        else cnt_d = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
        // every edge that lands the counter on 0 is a period boundary, including while disabled
        boundary = cnt_d == '0;
        dir_d = boundary ? 1'b0 : (mode_act_q && at_top) ? 1'b1 : dir_q;
        for (int i = 0; i < CH; i++) cmp[i] = cnt_q < duty_act_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            top_sh_q   <= '1;
            top_act_q  <= '1;
            mode_sh_q  <= 1'b0;
            mode_act_q <= 1'b0;
            pwm_q      <= '0;
            ps_q       <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            pwm_q <= enable ? (cmp ^ invert) : invert;
            ps_q  <= enable && (cnt_q == '0);
            if (cfg_load) begin
                top_sh_q  <= period_in;
                mode_sh_q <= center_in;
            end
            if (boundary) begin
                top_act_q  <= top_sh_q;
                mode_act_q <= mode_sh_q;
            end
            for (int i = 0; i < CH; i++) begin
                if (load && ch_sel == SELW'(i)) duty_sh_q[i] <= data_in;
                if (boundary) duty_act_q[i] <= duty_sh_q[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: randomized and directed checks of pwm_multi (CH=2, WIDTH=4) against a phase-based reference model
module tb_pwm_multi;
    localparam int CH = 2;
    localparam int W  = 4;

    logic          clk = 0, rst = 1, enable = 0, load = 0, cfg_load = 0, center_in = 0;
    logic [1:0]    ch_sel = 0;
    logic [W-1:0]  data_in = 0, period_in = 0;
    logic [CH-1:0] invert = 0;
    logic [CH-1:0] pwm_out;
    logic          period_start;
    int            passed = 0, total = 0;

    always #5 clk = ~clk;

    pwm_multi #(.CH(CH), .WIDTH(W), .SELW(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .ch_sel(ch_sel),
        .data_in(data_in), .cfg_load(cfg_load), .period_in(period_in),
        .center_in(center_in), .invert(invert), .pwm_out(pwm_out),
        .period_start(period_start)
    );

    // Reference: position within the period plus period length, counter value derived from the position
    int            m_ph, m_top_a, m_top_s;
    bit            m_ctr_a, m_ctr_s;
    int            m_da [CH];
    int            m_ds [CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    function automatic int m_len();
        return m_top_a == 0 ? 1 : m_ctr_a ? 2 * m_top_a : m_top_a + 1;
    endfunction

    function automatic int m_cnt();
        return (m_ctr_a && m_ph > m_top_a) ? 2 * m_top_a - m_ph : m_ph;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_top_a = 15; m_top_s = 15; m_ctr_a = 0; m_ctr_s = 0;
            for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
            exp_pwm = '0; exp_ps = 0;
        end else begin
            for (int i = 0; i < CH; i++)
                exp_pwm[i] = enable ? ((m_cnt() < m_da[i]) ^ invert[i]) : invert[i];
            exp_ps = enable && m_ph == 0;
            m_ph = enable ? m_ph + 1 : 0;
            if (m_ph >= m_len()) m_ph = 0;
            if (m_ph == 0) begin
                m_top_a = m_top_s; m_ctr_a = m_ctr_s;
                for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
            end
            if (cfg_load) begin m_top_s = period_in; m_ctr_s = center_in; end
            if (load && ch_sel < CH) m_ds[ch_sel] = data_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(output bit ok);
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            tick();
            ok = period_start;
        end
    endtask

    task automatic measure(input int n, output logic [31:0] w0, output logic [31:0] w1,
                           output logic [31:0] ps, output int diffs);
        w0 = 0; w1 = 0; ps = 0; diffs = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            w0[k] = pwm_out[0];
            w1[k] = pwm_out[1];
            ps[k] = period_start;
            if (pwm_out !== exp_pwm || period_start !== exp_ps) diffs++;
        end
    endtask

    task automatic set_duty(input int ch, input int d);
        ch_sel = 2'(ch); data_in = W'(d); load = 1;
        tick();
        load = 0;
    endtask

    task automatic set_cfg(input int top, input bit ctr);
        period_in = W'(top); center_in = ctr; cfg_load = 1;
        tick();
        cfg_load = 0;
    endtask

    task automatic test_reset();
        logic [31:0] w0, w1, ps;
        int d;
        rst = 0; enable = 1;
        set_duty(0, 5); set_duty(1, 9);
        repeat (21 + $urandom_range(0, 15)) tick();
        rst = 1;
        tick();
        total++; if (pwm_out !== 2'b00) $display("FAIL rst_pwm: got %b want 00", pwm_out); else passed++;
        total++; if (period_start !== 1'b0) $display("FAIL rst_ps: got %b want 0", period_start); else passed++;
        rst = 0;
        tick();
        measure(32, w0, w1, ps, d);
        total++; if (ps !== 32'h0001_0001) $display("FAIL rst_period16: got %h want 00010001", ps); else passed++;
        total++; if ((w0 | w1) !== 32'h0) $display("FAIL rst_low: got %h want 0", w0 | w1); else passed++;
        total++; if (d !== 0) $display("FAIL rst_model: got %0d diffs want 0", d); else passed++;
    endtask

    task automatic test_edge_sweep();
        int duty [5] = '{0, 1, 5, 10, 15};
        int hi   [5] = '{0, 1, 5, 10, 10};
        logic [31:0] w0, w1, ps;
        int d;
        bit ok1, ok2;
        set_cfg(9, 0);
        for (int j = 0; j < 5; j++) begin
            set_duty(0, duty[j]);
            set_duty(1, $urandom_range(0, 15));
            wait_ps(ok1); wait_ps(ok2);
            total++; if (!(ok1 && ok2)) $display("FAIL edge_wait: got timeout want period_start"); else passed++;
            measure(11, w0, w1, ps, d);
            total++; if (w0[9:0] !== 10'((1 << hi[j]) - 1))
                $display("FAIL edge_duty%0d: got %b want %0d high from start", duty[j], w0[9:0], hi[j]); else passed++;
            total++; if (ps[10:0] !== 11'h401) $display("FAIL edge_period: got %b want 10000000001", ps[10:0]); else passed++;
            total++; if (d !== 0) $display("FAIL edge_model: got %0d diffs want 0", d); else passed++;
        end
    endtask

    task automatic test_center();
        int duty [5] = '{0, 1, 3, 6, 7};
        int hi   [5] = '{0, 1, 5, 11, 12};
        logic [31:0] w0, w1, ps;
        int d;
        bit ok1, ok2, sym;
        set_cfg(6, 1);
        for (int j = 0; j < 5; j++) begin
            set_duty(0, duty[j]);
            set_duty(1, $urandom_range(0, 15));
            wait_ps(ok1); wait_ps(ok2);
            total++; if (!(ok1 && ok2)) $display("FAIL ctr_wait: got timeout want period_start"); else passed++;
            measure(13, w0, w1, ps, d);
            sym = 1;
            for (int k = 1; k < 6; k++) if (w0[k] !== w0[12-k]) sym = 0;
            total++; if ($countones(w0[11:0]) !== hi[j])
                $display("FAIL ctr_duty%0d: got %0d high want %0d", duty[j], $countones(w0[11:0]), hi[j]); else passed++;
            total++; if (sym !== 1'b1) $display("FAIL ctr_sym%0d: got %b want symmetric", duty[j], w0[11:0]); else passed++;
            total++; if (ps[12:0] !== 13'h1001) $display("FAIL ctr_period: got %b want period 12", ps[12:0]); else passed++;
            total++; if (d !== 0) $display("FAIL ctr_model: got %0d diffs want 0", d); else passed++;
        end
    endtask

    task automatic test_double_buffer();
        logic [31:0] w0, w1, ps;
        int d;
        bit ok1, ok2;
        set_cfg(9, 0);
        set_duty(1, 2);
        wait_ps(ok1); wait_ps(ok2);
        total++; if (!(ok1 && ok2)) $display("FAIL db_wait: got timeout want period_start"); else passed++;
        repeat (3) tick();
        set_duty(1, 8);
        measure(16, w0, w1, ps, d);
        total++; if (w1[15:0] !== 16'h3FC0) $display("FAIL db_midperiod: got %h want 3fc0", w1[15:0]); else passed++;
        total++; if (ps[15:0] !== 16'h0040) $display("FAIL db_mid_ps: got %h want 0040", ps[15:0]); else passed++;
        repeat (9) tick();
        set_duty(1, 3);
        measure(21, w0, w1, ps, d);
        total++; if (w1[20:0] !== 21'h0039FE) $display("FAIL db_boundary_load: got %h want 0039fe", w1[20:0]); else passed++;
        total++; if (ps[20:0] !== 21'h000802) $display("FAIL db_boundary_ps: got %h want 000802", ps[20:0]); else passed++;
        set_duty(3, 5);
        set_duty(2, 1);
        wait_ps(ok1); wait_ps(ok2);
        measure(10, w0, w1, ps, d);
        total++; if ({w1[9:0], w0[9:0]} !== {10'h007, 10'h07F})
            $display("FAIL db_bad_sel: got %h/%h want 007/07f", w1[9:0], w0[9:0]); else passed++;
        total++; if (d !== 0) $display("FAIL db_model: got %0d diffs want 0", d); else passed++;
    endtask

    task automatic test_config();
        logic [31:0] w0, w1, ps;
        int d;
        bit ok1, ok2;
        set_duty(0, 2);
        set_cfg(15, 0);
        wait_ps(ok1); wait_ps(ok2);
        total++; if (!(ok1 && ok2)) $display("FAIL cfg_wait: got timeout want period_start"); else passed++;
        repeat (6) tick();
        set_cfg(3, 0);
        measure(17, w0, w1, ps, d);
        total++; if (ps[16:0] !== 17'h02200) $display("FAIL cfg_shrink_ps: got %h want 02200", ps[16:0]); else passed++;
        total++; if (w0[16:0] !== 17'h06600) $display("FAIL cfg_shrink_pwm: got %h want 06600", w0[16:0]); else passed++;
        set_cfg(3, 1);
        measure(11, w0, w1, ps, d);
        total++; if (ps[10:0] !== 11'h411) $display("FAIL cfg_center_ps: got %h want 411", ps[10:0]); else passed++;
        total++; if (w0[10:0] !== 11'h633) $display("FAIL cfg_center_pwm: got %h want 633", w0[10:0]); else passed++;
        total++; if (d !== 0) $display("FAIL cfg_model: got %0d diffs want 0", d); else passed++;
    endtask

    task automatic test_enable_invert();
        logic [31:0] w0a, w1a, w0b, w1b, ps;
        int d;
        set_cfg(9, 0);
        enable = 0;
        invert = 2'b10;
        set_duty(0, 4);
        set_duty(1, 7);
        repeat (3) tick();
        total++; if (pwm_out !== invert) $display("FAIL dis_pwm: got %b want %b", pwm_out, invert); else passed++;
        total++; if (period_start !== 1'b0) $display("FAIL dis_ps: got %b want 0", period_start); else passed++;
        invert = 2'b00;
        tick();
        enable = 1;
        tick();
        total++; if (period_start !== 1'b1) $display("FAIL en_first_ps: got %b want 1", period_start); else passed++;
        total++; if (pwm_out !== 2'b11) $display("FAIL en_first_pwm: got %b want 11", pwm_out); else passed++;
        measure(10, w0a, w1a, ps, d);
        total++; if (w0a[9:0] !== 10'h00F) $display("FAIL en_plain: got %h want 00f", w0a[9:0]); else passed++;
        invert = 2'b01;
        tick();
        measure(10, w0b, w1b, ps, d);
        total++; if (w0b[9:0] !== ~w0a[9:0]) $display("FAIL inv_ch0: got %h want %h", w0b[9:0], ~w0a[9:0]); else passed++;
        total++; if (w1b[9:0] !== w1a[9:0]) $display("FAIL inv_ch1: got %h want %h", w1b[9:0], w1a[9:0]); else passed++;
        total++; if (d !== 0) $display("FAIL inv_model: got %0d diffs want 0", d); else passed++;
        repeat (5) tick();
        rst = 1;
        tick();
        total++; if ({pwm_out, period_start} !== 3'b000)
            $display("FAIL rst_mid: got %b%b want 000", pwm_out, period_start); else passed++;
        rst = 0;
        tick();
        total++; if (period_start !== 1'b1) $display("FAIL rst_restart_ps: got %b want 1", period_start); else passed++;
        total++; if (pwm_out !== 2'b01) $display("FAIL rst_restart_pwm: got %b want 01", pwm_out); else passed++;
    endtask

    initial begin
        tick();
        total++; if ({pwm_out, period_start} !== 3'b000)
            $display("FAIL reset_state: got %b%b want 000", pwm_out, period_start); else passed++;
        test_reset();
        test_edge_sweep();
        test_center();
        test_double_buffer();
        test_config();
        test_enable_invert();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
